// File: rtl/crc_three_pkg.sv
// crc_three_pkg: shared constants, state encoding and syndrome lookup for the (7,3) cyclic decoder
package crc_three_pkg;
  localparam int CW_LEN = 7;
  localparam int DATA_LEN = 3;
  localparam int CRC_LEN = 4;
  localparam logic [CRC_LEN-1:0] GEN_POLY = 4'b0111;
  localparam logic [CW_LEN*CRC_LEN-1:0] SYN_TABLE = {4'b1011, 4'b1110, 4'b0111, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
  typedef enum logic [1:0] {S_RECV, S_EVAL, S_OUT} state_t;
  function automatic logic [3:0] syn_lookup(input logic [CRC_LEN-1:0] s);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < CW_LEN; i++)
      if (s == SYN_TABLE[CRC_LEN*i +: CRC_LEN]) r = {1'b1, 3'(i)};
    return r;
  endfunction
endpackage

// File: rtl/crc_three_syn_lfsr.sv
// crc_three_syn_lfsr: serial syndrome register dividing the received stream by g(x)
module crc_three_syn_lfsr
  import crc_three_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               din,
  output logic [CRC_LEN-1:0] syn
);
  always_ff @(posedge clk)
    if (rst || clr) syn <= '0;
    else if (en) syn <= {syn[CRC_LEN-2:0], din} ^ (syn[CRC_LEN-1] ? GEN_POLY : '0);
endmodule

// File: rtl/crc_three_dec.sv
// crc_three_dec: serial (7,3) cyclic code decoder with single-bit correction and valid/ready handshakes
module crc_three_dec
  import crc_three_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic                i_bit,
  output logic                o_ready,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [DATA_LEN-1:0] o_data,
  output logic [CRC_LEN-1:0]  o_syndrome,
  output logic                o_corrected,
  output logic                o_uncorr,
  output logic [2:0]          o_err_pos
);
  state_t state, state_nxt;
  logic [2:0] cnt;
  logic [CW_LEN-1:0] word, flip, fixed;
  logic [CRC_LEN-1:0] syn;
  logic [3:0] hit_pos;
  logic acc, done;
  assign o_ready = state == S_RECV && !i_rst;
  assign o_valid = state == S_OUT;
  assign acc = i_valid && o_ready;
  assign done = state == S_OUT && i_ready;
  assign hit_pos = syn_lookup(syn);
  assign flip = hit_pos[3] ? CW_LEN'(1) << hit_pos[2:0] : '0;
  assign fixed = word ^ flip;
  crc_three_syn_lfsr u_syn (
    .clk(i_clk),
    .rst(i_rst),
    .clr(done),
    .en (acc),
    .din(i_bit),
    .syn(syn)
  );
  always_comb
    state_nxt = state == S_RECV ? (acc && cnt == 3'd6 ? S_EVAL : S_RECV)
              : state == S_EVAL ? S_OUT
              : (i_ready ? S_RECV : S_OUT);
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state       <= S_RECV;
      cnt         <= '0;
      word        <= '0;
      o_data      <= '0;
      o_syndrome  <= '0;
      o_corrected <= 1'b0;
      o_uncorr    <= 1'b0;
      o_err_pos   <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        word <= {word[CW_LEN-2:0], i_bit};
        cnt  <= cnt == 3'd6 ? 3'd0 : cnt + 3'd1;
      end
      if (done) word <= '0;
      if (state == S_EVAL) begin
        o_data      <= fixed[CW_LEN-1 -: DATA_LEN];
        o_syndrome  <= syn;
        o_corrected <= hit_pos[3];
        o_uncorr    <= |syn && !hit_pos[3];
        o_err_pos   <= hit_pos[3] ? hit_pos[2:0] : 3'd0;
      end
    end
endmodule

// File: tb/tb_crc_three_dec.sv
// tb_crc_three_dec: randomized self-checking bench against a polynomial-division and nearest-codeword model
module tb_crc_three_dec;
  logic clk = 1'b0;
  logic rst, in_valid, in_bit, out_ready, out_valid, dn_ready;
  logic [2:0] data, err_pos;
  logic [3:0] syndrome;
  logic corrected, uncorr;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  crc_three_dec dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_valid(in_valid),
    .i_bit(in_bit),
    .o_ready(out_ready),
    .o_valid(out_valid),
    .i_ready(dn_ready),
    .o_data(data),
    .o_syndrome(syndrome),
    .o_corrected(corrected),
    .o_uncorr(uncorr),
    .o_err_pos(err_pos)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] rem7(input logic [6:0] r);
    logic [6:0] t, g;
    t = r;
    for (int i = 6; i >= 4; i--) begin
      g = 7'b0010111 << (i - 4);
      if (t[i]) t = t ^ g;
    end
    return t[3:0];
  endfunction
  function automatic logic [6:0] encode(input logic [2:0] d);
    logic [6:0] c;
    c = {d, 4'b0000};
    return c | {3'b000, rem7(c)};
  endfunction
  task automatic run_word(input logic [6:0] w, input bit gaps, input int hold);
    logic [3:0] s;
    logic [6:0] t, u;
    logic [2:0] d, pos;
    logic cor, unc;
    s = rem7(w);
    d = w[6:4];
    cor = 1'b0;
    pos = 3'd0;
    for (int k = 0; k < 7; k++) begin
      t = w ^ (7'b1 << k);
      if (s != 4'd0 && rem7(t) == 4'd0) begin
        cor = 1'b1;
        pos = 3'(k);
        u = t;
        d = u[6:4];
      end
    end
    unc = s != 4'd0 && !cor;
    for (int i = 6; i >= 0; i--) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_bit = 1'($urandom_range(0, 1));
        tick;
      end
      in_valid = 1'b1;
      in_bit = w[i];
      check("ready_recv", out_ready, 1'b1);
      tick;
    end
    in_valid = 1'($urandom_range(0, 1));
    in_bit = 1'($urandom_range(0, 1));
    check("eval_valid", out_valid, 1'b0);
    check("eval_ready", out_ready, 1'b0);
    tick;
    check("out_valid", out_valid, 1'b1);
    for (int h = 0; h <= hold; h++) begin
      dn_ready = h == hold;
      check("data", data, d);
      check("syndrome", syndrome, s);
      check("corrected", corrected, cor);
      check("uncorr", uncorr, unc);
      check("err_pos", err_pos, pos);
      check("out_ready", out_ready, 1'b0);
      check("hold_valid", out_valid, 1'b1);
      in_valid = 1'($urandom_range(0, 1));
      in_bit = 1'($urandom_range(0, 1));
      tick;
    end
    dn_ready = 1'b0;
    in_valid = 1'b0;
    check("post_valid", out_valid, 1'b0);
    check("post_ready", out_ready, 1'b1);
  endtask
  initial begin
    logic [6:0] w;
    logic [2:0] a, b;
    rst = 1'b1;
    in_valid = 1'b0;
    in_bit = 1'b0;
    dn_ready = 1'b0;
    tick;
    tick;
    check("rst_ready", out_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_rel_ready", out_ready, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_out", {data, syndrome, corrected, uncorr, err_pos}, 32'd0);
    run_word(7'b1011100, 1'b0, 0);
    run_word(7'b0011100, 1'b0, 0);
    run_word(7'b1011101, 1'b0, 0);
    run_word(7'b0111100, 1'b0, 0);
    run_word(7'b1011100, 1'b1, 5);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_bit = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    check("midrst_ready", out_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_rel", out_ready, 1'b1);
    run_word(7'b0101110, 1'b0, 0);
    for (int n = 0; n < 40; n++) begin
      w = encode(3'($urandom_range(0, 7)));
      a = 3'($urandom_range(0, 6));
      b = 3'((a + 1 + $urandom_range(0, 5)) % 7);
      case ($urandom_range(0, 3))
        1: w = w ^ (7'b1 << a);
        2: w = w ^ (7'b1 << a) ^ (7'b1 << b);
        3: w = 7'($urandom_range(0, 127));
        default: ;
      endcase
      run_word(w, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
